// File: rtl/pit_irq_ctrl.sv
// Prioritised interrupt aggregator for PIT irq lines: edge capture, pending/overrun tracking, one held request.
// Define PIT_IRQ_RR_EN for round-robin arbitration; the default build uses fixed priority (index 0 highest).
module pit_irq_ctrl #(
  parameter int NUM_SRC = 4,
  parameter int VEC_W   = 2
) (
  input  logic               wb_clk_i,
  input  logic               async_rst_b,
  input  logic [NUM_SRC-1:0] irq_i,
  input  logic               mask_we_i,
  input  logic [NUM_SRC-1:0] mask_i,
  input  logic               ovr_clr_i,
  input  logic               irq_ack_i,
  output logic               irq_o,
  output logic [VEC_W-1:0]   irq_vec_o,
  output logic [NUM_SRC-1:0] pend_o,
  output logic [NUM_SRC-1:0] ovr_o
);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] irq_hist_q, irq_hist_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] ovr_q, ovr_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic               req_q, req_d;
  logic [VEC_W-1:0]   vec_q, vec_d;

  logic [NUM_SRC-1:0] rise, clr, cand;
  logic [VEC_W-1:0]   sel;
  logic               sel_valid;

  assign rise = irq_i & ~irq_hist_q;
  assign cand = pend_q & ~mask_q;

`ifdef PIT_IRQ_RR_EN
  logic [VEC_W-1:0] ptr_q, ptr_d;

  // Two passes: indices above the last grant first, then wrap to the bottom.
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!sel_valid && cand[i] && (i > int'(ptr_q))) begin
        sel       = VEC_W'(i);
        sel_valid = 1'b1;
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!sel_valid && cand[i]) begin
        sel       = VEC_W'(i);
        sel_valid = 1'b1;
      end
    end
  end

  assign ptr_d = (state_q == REQ && irq_ack_i) ? vec_q : ptr_q;

  always_ff @(posedge wb_clk_i or negedge async_rst_b) begin
    if (!async_rst_b) ptr_q <= VEC_W'(NUM_SRC - 1);
    else              ptr_q <= ptr_d;
  end
`else
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!sel_valid && cand[i]) begin
        sel       = VEC_W'(i);
        sel_valid = 1'b1;
      end
    end
  end
`endif

  // NOTE: every signal assigned in a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    vec_d   = '0;
    clr     = '0;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          state_d = REQ;
          req_d   = 1'b1;
          vec_d   = sel;
        end
      end
      REQ: begin
        req_d = 1'b1;
        vec_d = vec_q;
        if (irq_ack_i) begin
          clr[vec_q] = 1'b1;
          state_d    = GAP;
          req_d      = 1'b0;
          vec_d      = '0;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A new edge always wins over an acknowledge or an overrun clear in the same cycle.
  always_comb begin
    irq_hist_d = irq_i;
    pend_d     = (pend_q & ~clr) | rise;
    ovr_d      = (ovr_clr_i ? '0 : ovr_q) | (rise & pend_q & ~clr);
    mask_d     = mask_we_i ? mask_i : mask_q;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge wb_clk_i or negedge async_rst_b) begin
    if (!async_rst_b) begin
      state_q    <= IDLE;
      irq_hist_q <= '0;
      pend_q     <= '0;
      ovr_q      <= '0;
      mask_q     <= '0;
      req_q      <= 1'b0;
      vec_q      <= '0;
    end else begin
      state_q    <= state_d;
      irq_hist_q <= irq_hist_d;
      pend_q     <= pend_d;
      ovr_q      <= ovr_d;
      mask_q     <= mask_d;
      req_q      <= req_d;
      vec_q      <= vec_d;
    end
  end

  assign irq_o     = req_q;
  assign irq_vec_o = vec_q;
  assign pend_o    = pend_q;
  assign ovr_o     = ovr_q;

endmodule

// File: tb/tb_pit_irq_ctrl.sv
// Self-checking bench for pit_irq_ctrl: directed test-plan steps, then random traffic against a
// cycle-level reference model built from the pending/overrun/arbitration rules.
module tb_pit_irq_ctrl;
  localparam int N  = 4;
  localparam int VW = 2;

  logic          wb_clk_i = 1'b0;
  logic          async_rst_b;
  logic [N-1:0]  irq_i, mask_i;
  logic          mask_we_i, ovr_clr_i, irq_ack_i;
  logic          irq_o;
  logic [VW-1:0] irq_vec_o;
  logic [N-1:0]  pend_o, ovr_o;

  pit_irq_ctrl #(.NUM_SRC(N), .VEC_W(VW)) dut (
    .wb_clk_i   (wb_clk_i),
    .async_rst_b(async_rst_b),
    .irq_i      (irq_i),
    .mask_we_i  (mask_we_i),
    .mask_i     (mask_i),
    .ovr_clr_i  (ovr_clr_i),
    .irq_ack_i  (irq_ack_i),
    .irq_o      (irq_o),
    .irq_vec_o  (irq_vec_o),
    .pend_o     (pend_o),
    .ovr_o      (ovr_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: what the host should observe after each edge.
  bit [N-1:0] m_prev, m_pend, m_ovr, m_mask;
  bit         m_req;
  int         m_vec;
  int         m_gap;
  int         m_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = '0; m_pend = '0; m_ovr = '0; m_mask = '0;
    m_req  = 1'b0; m_vec = 0; m_gap = 0; m_last = N - 1;
  endtask

  function automatic int pick(input bit [N-1:0] c);
`ifdef PIT_IRQ_RR_EN
    for (int k = 1; k <= N; k++)
      if (c[(m_last + k) % N]) return (m_last + k) % N;
`else
    for (int i = 0; i < N; i++)
      if (c[i]) return i;
`endif
    return -1;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit [N-1:0] rise, clr;
    int p;
    rise = irq_i & ~m_prev;
    clr  = '0;
    if (m_req) begin
      if (irq_ack_i) begin
        clr[m_vec] = 1'b1;
        m_last     = m_vec;
        m_req      = 1'b0;
        m_gap      = 1;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      p = pick(m_pend & ~m_mask);
      if (p >= 0) begin
        m_req = 1'b1;
        m_vec = p;
      end
    end
    m_ovr  = (ovr_clr_i ? '0 : m_ovr) | (rise & m_pend & ~clr);
    m_pend = (m_pend & ~clr) | rise;
    if (mask_we_i) m_mask = mask_i;
    m_prev = irq_i;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".irq_o"}, irq_o, m_req);
    check({tag, ".irq_vec_o"}, irq_vec_o, m_req ? m_vec : 0);
    check({tag, ".pend_o"}, pend_o, m_pend);
    check({tag, ".ovr_o"}, ovr_o, m_ovr);
  endtask

  task automatic step(input string tag = "step");
    model_edge();
    @(posedge wb_clk_i);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    async_rst_b = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    @(posedge wb_clk_i);
    #1;
    async_rst_b = 1'b1;
  endtask

  initial begin
    irq_i = '0; mask_i = '0; mask_we_i = 1'b0; ovr_clr_i = 1'b0; irq_ack_i = 1'b0;
    async_rst_b = 1'b0;
    model_reset();
    repeat (2) @(posedge wb_clk_i);
    #1;
    compare_all("reset");
    check("reset.irq_o", irq_o, 0);
    check("reset.pend_o", pend_o, 0);
    async_rst_b = 1'b1;

    // Single source: two-cycle latency, ack clears pending and opens the gap.
    step(); step();
    irq_i = 4'b0100;
    step("t1");
    check("t1.pend_set", pend_o, 4'b0100);
    check("t1.irq_not_yet", irq_o, 0);
    step("t1");
    check("t1.irq_high", irq_o, 1);
    check("t1.vec", irq_vec_o, 2);
    step("t1");
    irq_ack_i = 1'b1;
    step("t1");
    irq_ack_i = 1'b0;
    check("t1.ack_pend", pend_o, 0);
    check("t1.gap_irq", irq_o, 0);

    // Simultaneous sources: lowest index first, next grant three cycles after the ack.
    irq_i = '0;
    step(); step(); step();
    irq_i = 4'b1010;
    step("t2"); step("t2");
    check("t2.first_vec", irq_vec_o, 1);
    irq_ack_i = 1'b1;
    step("t2");
    irq_ack_i = 1'b0;
    check("t2.gap", irq_o, 0);
    step("t2");
    check("t2.idle", irq_o, 0);
    step("t2");
    check("t2.second_irq", irq_o, 1);
    check("t2.second_vec", irq_vec_o, 3);
    irq_ack_i = 1'b1;
    step("t2");
    irq_ack_i = 1'b0;
    irq_i = '0;
    step(); step();

    // Overrun set, clear, and clear colliding with a new overrun.
    irq_i = 4'b0001;
    step("t3");
    irq_i = '0;
    step("t3");
    irq_i = 4'b0001;
    step("t3");
    check("t3.ovr_set", ovr_o, 4'b0001);
    irq_i = '0;
    ovr_clr_i = 1'b1;
    step("t3");
    ovr_clr_i = 1'b0;
    check("t3.ovr_clr", ovr_o, 0);
    irq_i = 4'b0001;
    ovr_clr_i = 1'b1;
    step("t3");
    ovr_clr_i = 1'b0;
    irq_i = '0;
    check("t3.ovr_set_wins", ovr_o, 4'b0001);
    irq_ack_i = 1'b1;
    step("t3");
    irq_ack_i = 1'b0;
    step(); step();

    // Masked source latches pending but raises no request until unmasked.
    mask_we_i = 1'b1; mask_i = 4'b0001;
    step("t4");
    mask_we_i = 1'b0;
    irq_i = 4'b0001;
    step("t4"); step("t4"); step("t4");
    check("t4.masked_pend", pend_o[0], 1);
    check("t4.masked_irq", irq_o, 0);
    mask_we_i = 1'b1; mask_i = 4'b0000;
    step("t4");
    mask_we_i = 1'b0;
    check("t4.unmask_lat1", irq_o, 0);
    step("t4");
    check("t4.unmask_irq", irq_o, 1);
    check("t4.unmask_vec", irq_vec_o, 0);
    irq_ack_i = 1'b1;
    step("t4");
    irq_ack_i = 1'b0;
    irq_i = '0;
    step(); step();

    // Active request is not pre-empted; ack colliding with a re-rise keeps pending set.
    irq_i = 4'b0100;
    step("t5"); step("t5");
    irq_i = 4'b0101;
    step("t5");
    check("t5.hold_vec", irq_vec_o, 2);
    irq_i = 4'b0001;
    step("t5");
    check("t5.hold_vec2", irq_vec_o, 2);
    irq_i = 4'b0101;
    irq_ack_i = 1'b1;
    step("t5");
    irq_ack_i = 1'b0;
    check("t5.pend_kept", pend_o[2], 1);
    check("t5.gap", irq_o, 0);
    irq_i = '0;
    repeat (8) begin
      irq_ack_i = irq_o;
      step("t5");
    end
    irq_ack_i = 1'b0;

    // Random traffic with one asynchronous reset in the middle.
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      irq_i     = irq_i ^ N'($urandom & $urandom);
      irq_ack_i = ($urandom_range(0, 2) == 0);
      ovr_clr_i = ($urandom_range(0, 15) == 0);
      mask_we_i = ($urandom_range(0, 24) == 0);
      mask_i    = N'($urandom);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
